fifo_reader_serializer: RTL and testbench
=========================================

Name: fifo_reader_serializer

Overview:
Upstream stage of the DMA read verifier. On a start pulse, pops 32-bit words from the read-data FIFO and serializes each word MSB-byte-first onto an 8-bit valid/ready byte stream. It stops after exactly i_RCC_BUFFER_LENGTH bytes and then pulses a done flag. The verifier consumes the FIFO read strobe, byte stream, byte index and done flag to drive its own DMA re-reads and compare data.

Parameters:
LEN_W, 6, width of the byte-length field (max transfer 2^LEN_W-1 bytes)

Ports:
CLK  input  1  clock, all logic on posedge
RESET  input  1  synchronous, active-high reset
i_ReaderStart  input  1  one-cycle start pulse; honoured only in IDLE
i_RCC_BUFFER_LENGTH  input  LEN_W  bytes to emit; sampled on accepted start
i_fifo_empty  input  1  read-data FIFO empty flag
i_fifo_dout  input  32  FIFO read data, valid one cycle after rd_en
i_out_ready  input  1  downstream byte accept
o_Reader_FIFO_rd_en  output  1  FIFO pop strobe
o_serialized_output  output  8  current byte
o_serialized_output_valid  output  1  byte valid
o_Serialize_Counter  output  2  byte index within word, 0 = bits[31:24]
o_FIFO_Reader_Done  output  1  one-cycle completion pulse
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE. All outputs 0. Word register, remaining count and index cleared.
- Reset takes priority over all other inputs. Reset mid-transfer aborts immediately, with no done pulse and no further rd_en.
- States: IDLE, FETCH, WAIT, SHIFT, DONE.
- IDLE, start seen:
  - Latch remaining = i_RCC_BUFFER_LENGTH.
  - If length == 0, go to DONE with no FIFO reads; otherwise go to FETCH.
  - Start is ignored in every other state.
- FETCH:
  - o_Reader_FIFO_rd_en = 1 combinationally when !i_fifo_empty, then go to WAIT.
  - While empty: rd_en = 0 and stay in FETCH, with no timeout.
  - rd_en is asserted only in FETCH, and at most one cycle per word.
- WAIT: capture i_fifo_dout into the word register, set idx = 0, go to SHIFT.
- SHIFT:
  - Outputs: valid = 1, o_serialized_output = word[31-8*idx -: 8], o_Serialize_Counter = idx.
  - A transfer occurs when valid && i_out_ready.
  - While !i_out_ready, byte, index and valid are held stable.
  - On transfer: remaining -= 1 and idx += 1 (2-bit wrap).
    - If remaining was 1, go to DONE.
    - Else if idx was 3, go to FETCH.
    - Else stay in SHIFT.
- Partial last word: when length mod 4 != 0, the unused low bytes of the final word are discarded. The word is still popped exactly once.
- DONE: o_FIFO_Reader_Done = 1 for exactly one cycle, valid = 0, then return to IDLE. A start is accepted again on the following cycle.
- Word count popped = ceil(length/4); maximum is 16 words for length 63.
- Latency, with start at cycle 0, non-empty FIFO and ready high:
  - rd_en at cycle 1; first byte valid at cycle 3.
  - Subsequent bytes of the same word come one per cycle.
  - Each word boundary costs 2 bubble cycles (FETCH, WAIT).
  - Done is asserted the cycle after the last transfer.
- valid is low in IDLE, FETCH, WAIT and DONE.
- o_busy = (state != IDLE).

Test Plan:
- Length 8, FIFO holds 0xA1B2C3D4 then 0x11223344, ready = 1:
  - Bytes A1, B2, C3, D4, 11, 22, 33, 44 with counter 0,1,2,3,0,1,2,3.
  - Exactly 2 rd_en pulses; first valid at cycle 3.
  - Done for 1 cycle right after byte 44; FIFO not popped again.
- Length 5, words 0xDEADBEEF and 0xCAFEF00D: bytes DE, AD, BE, EF, CA, then done. 2 pops; F0 and 0D are never driven valid.
- Length 0 start: no rd_en, no valid, done pulses at cycle 1, busy high for 1 cycle.
- FIFO empty for 5 cycles in FETCH, then word 0x01020304 arrives, length 4: rd_en stays low for those cycles and pulses once after empty deasserts. Bytes 01..04 follow, then done.
- Length 4, i_out_ready toggles 1,0,0,1,...: each byte held with the same counter while ready = 0. Exactly 4 transfers, no byte duplicated or skipped.
- Length 12 with RESET asserted during the second word: outputs go to 0 next cycle, no done, no further rd_en. A new start with length 4 afterwards runs correctly.

Source files
------------

// File: rtl/fifo_reader_serializer.sv
// Pops 32-bit words from the read-data FIFO and streams them MSB byte first
// as a valid/ready byte stream, stopping after a programmed byte count.
module fifo_reader_serializer #(
   parameter int LEN_W = 6
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             i_ReaderStart,
   input  logic [LEN_W-1:0] i_RCC_BUFFER_LENGTH,
   input  logic             i_fifo_empty,
   input  logic [31:0]      i_fifo_dout,
   input  logic             i_out_ready,
   output logic             o_Reader_FIFO_rd_en,
   output logic [7:0]       o_serialized_output,
   output logic             o_serialized_output_valid,
   output logic [1:0]       o_Serialize_Counter,
   output logic             o_FIFO_Reader_Done,
   output logic             o_busy
);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;

   state_t           state;
   state_t           state_n;
   logic [31:0]      word;
   logic [31:0]      shifted;
   logic [LEN_W-1:0] remaining;
   logic [1:0]       idx;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         word      <= '0;
         remaining <= '0;
         idx       <= '0;
      end else begin
         state <= state_n;
         case (state)
            IDLE: begin
               if (i_ReaderStart) remaining <= i_RCC_BUFFER_LENGTH;
            end
            WAIT: begin
               word <= i_fifo_dout;
               idx  <= '0;
            end
            SHIFT: begin
               if (i_out_ready) begin
                  remaining <= remaining - 1'b1;
                  idx       <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // idx 0 selects bits [31:24]: shift right by 8*(3-idx)
   assign shifted = word >> {~idx, 3'b000};

   always_comb begin
      state_n                   = state;
      o_Reader_FIFO_rd_en       = 1'b0;
      o_serialized_output       = '0;
      o_serialized_output_valid = 1'b0;
      o_Serialize_Counter       = '0;
      o_FIFO_Reader_Done        = 1'b0;
      case (state)
         IDLE: begin
            if (i_ReaderStart) begin
               if (i_RCC_BUFFER_LENGTH == '0) state_n = DONE;
               else                           state_n = FETCH;
            end
         end
         FETCH: begin
            if (!i_fifo_empty) begin
               o_Reader_FIFO_rd_en = 1'b1;
               state_n             = WAIT;
            end
         end
         WAIT: begin
            state_n = SHIFT;
         end
         SHIFT: begin
            o_serialized_output_valid = 1'b1;
            o_serialized_output       = shifted[7:0];
            o_Serialize_Counter       = idx;
            if (i_out_ready) begin
               if (remaining == LEN_W'(1)) state_n = DONE;
               else if (idx == 2'd3)        state_n = FETCH;
            end
         end
         DONE: begin
            o_FIFO_Reader_Done = 1'b1;
            state_n            = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign o_busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_reader_serializer.sv
// Scoreboard bench for fifo_reader_serializer: directed words, expected
// bytes queued at stimulus time and checked by a negedge monitor.
module tb_fifo_reader_serializer;

   localparam int LEN_W = 6;

   logic             CLK = 1'b0;
   logic             RESET = 1'b1;
   logic             i_ReaderStart = 1'b0;
   logic [LEN_W-1:0] len = '0;
   logic             i_fifo_empty = 1'b1;
   logic [31:0]      i_fifo_dout = '0;
   logic             i_out_ready = 1'b1;
   logic             rd_en;
   logic [7:0]       out_byte;
   logic             out_valid;
   logic [1:0]       out_cnt;
   logic             done;
   logic             busy;

   always #5 CLK = ~CLK;

   fifo_reader_serializer #(.LEN_W(LEN_W)) dut (
      .CLK                       (CLK),
      .RESET                     (RESET),
      .i_ReaderStart             (i_ReaderStart),
      .i_RCC_BUFFER_LENGTH       (len),
      .i_fifo_empty              (i_fifo_empty),
      .i_fifo_dout               (i_fifo_dout),
      .i_out_ready               (i_out_ready),
      .o_Reader_FIFO_rd_en       (rd_en),
      .o_serialized_output       (out_byte),
      .o_serialized_output_valid (out_valid),
      .o_Serialize_Counter       (out_cnt),
      .o_FIFO_Reader_Done        (done),
      .o_busy                    (busy)
   );

   logic [31:0] fifo_q[$];
   logic [9:0]  exp_q[$];
   logic        hold_empty = 1'b0;
   logic        hold_chk = 1'b0;
   logic [9:0]  held = '0;
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int s0 = 0;
   int first_v = -1;
   int rd_cnt = 0;
   int done_cnt = 0;
   int xfer_cnt = 0;
   int last_x = -1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   // FIFO model: pop on rd_en, data and empty flag registered
   always @(posedge CLK) begin
      cyc++;
      if (rd_en && fifo_q.size() > 0) i_fifo_dout <= fifo_q.pop_front();
      i_fifo_empty <= hold_empty || (fifo_q.size() == 0);
   end

   always @(negedge CLK) begin
      if (!RESET) begin
         if (rd_en) rd_cnt++;
         if (hold_chk) begin
            hold_chk = 1'b0;
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_byte", 32'({out_cnt, out_byte}), 32'(held));
         end
         if (out_valid) begin
            if (first_v < 0) first_v = cyc - s0;
            if (!i_out_ready) begin
               held     = {out_cnt, out_byte};
               hold_chk = 1'b1;
            end else if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_byte actual=%0h required=none",
                        {out_cnt, out_byte});
            end else begin
               chk("byte", 32'({out_cnt, out_byte}), 32'(exp_q.pop_front()));
               xfer_cnt++;
               last_x = cyc;
            end
         end
         if (done) begin
            done_cnt++;
            chk("done_valid_low", 32'(out_valid), 32'd0);
            chk("done_all_bytes", exp_q.size(), 0);
            if (last_x >= 0) chk("done_latency", cyc - last_x, 1);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic load(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input int nw, input int n);
      logic [31:0] w[3];
      logic [31:0] b;
      w[0] = w0;
      w[1] = w1;
      w[2] = w2;
      for (int i = 0; i < nw; i++) fifo_q.push_back(w[i]);
      for (int i = 0; i < n; i++) begin
         b = w[i/4] >> (8 * (3 - (i % 4)));
         exp_q.push_back({2'(i % 4), b[7:0]});
      end
   endtask

   task automatic start(input int n);
      rd_cnt        = 0;
      xfer_cnt      = 0;
      first_v       = -1;
      last_x        = -1;
      len           = LEN_W'(n);
      i_ReaderStart = 1'b1;
      s0            = cyc;
      tick();
      i_ReaderStart = 1'b0;
   endtask

   task automatic wait_done(input int n, input int d0);
      int k = 0;
      while (done_cnt == d0 && k < n) begin
         tick();
         k++;
      end
      tick();
      chk("done_seen", done_cnt, d0 + 1);
      repeat (3) tick();
      chk("done_once", done_cnt, d0 + 1);
   endtask

   int d0;
   int r0;
   int k;

   initial begin
      repeat (3) tick();
      chk("rst_rd_en", 32'(rd_en), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_byte", 32'(out_byte), 32'd0);
      chk("rst_cnt", 32'(out_cnt), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      RESET = 1'b0;
      tick();

      // two full words
      load(32'hA1B2C3D4, 32'h11223344, 32'h0, 2, 8);
      d0 = done_cnt;
      start(8);
      chk("t1_rd_en_cyc1", 32'(rd_en), 32'd1);
      wait_done(40, d0);
      chk("t1_rd_cnt", rd_cnt, 2);
      chk("t1_first_valid", first_v, 3);
      chk("t1_xfers", xfer_cnt, 8);

      // partial last word
      load(32'hDEADBEEF, 32'hCAFEF00D, 32'h0, 2, 5);
      d0 = done_cnt;
      start(5);
      wait_done(40, d0);
      chk("t2_rd_cnt", rd_cnt, 2);
      chk("t2_xfers", xfer_cnt, 5);

      // zero length
      d0 = done_cnt;
      start(0);
      chk("t3_done_c1", 32'(done), 32'd1);
      chk("t3_busy_c1", 32'(busy), 32'd1);
      chk("t3_rd_en_c1", 32'(rd_en), 32'd0);
      tick();
      chk("t3_busy_c2", 32'(busy), 32'd0);
      chk("t3_done_c2", 32'(done), 32'd0);
      chk("t3_done_cnt", done_cnt, d0 + 1);
      repeat (3) tick();
      chk("t3_rd_cnt", rd_cnt, 0);

      // FIFO empty while fetching
      hold_empty = 1'b1;
      load(32'h01020304, 32'h0, 32'h0, 1, 4);
      d0 = done_cnt;
      start(4);
      repeat (4) tick();
      chk("t4_no_rd_en", rd_cnt, 0);
      chk("t4_busy", 32'(busy), 32'd1);
      hold_empty = 1'b0;
      wait_done(30, d0);
      chk("t4_rd_cnt", rd_cnt, 1);
      chk("t4_xfers", xfer_cnt, 4);

      // ready toggling 1,0,0
      load(32'h55667788, 32'h0, 32'h0, 1, 4);
      d0 = done_cnt;
      start(4);
      k = 0;
      while (done_cnt == d0 && k < 60) begin
         i_out_ready = (k % 3 == 0);
         tick();
         k++;
      end
      i_out_ready = 1'b1;
      tick();
      chk("t5_done", done_cnt, d0 + 1);
      chk("t5_xfers", xfer_cnt, 4);
      chk("t5_rd_cnt", rd_cnt, 1);

      // reset during second word
      load(32'h10203040, 32'h50607080, 32'h90A0B0C0, 3, 12);
      start(12);
      k = 0;
      while (!(rd_cnt == 2 && out_valid) && k < 40) begin
         tick();
         k++;
      end
      chk("t6_reach_word2", 32'(rd_cnt == 2 && out_valid), 32'd1);
      RESET = 1'b1;
      tick();
      chk("t6_rst_valid", 32'(out_valid), 32'd0);
      chk("t6_rst_rd_en", 32'(rd_en), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_byte", 32'(out_byte), 32'd0);
      exp_q.delete();
      fifo_q.delete();
      RESET = 1'b0;
      d0 = done_cnt;
      r0 = rd_cnt;
      repeat (5) tick();
      chk("t6_no_done", done_cnt, d0);
      chk("t6_no_rd_en", rd_cnt, r0);

      load(32'hCAFEBABE, 32'h0, 32'h0, 1, 4);
      d0 = done_cnt;
      start(4);
      wait_done(30, d0);
      chk("t7_rd_cnt", rd_cnt, 1);
      chk("t7_xfers", xfer_cnt, 4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
